// File: rtl/if_id_pipe_reg.sv
//-----------------------------------------------------------------------------
// if_id_pipe_reg
//
// IF/ID pipeline register. Fetch delivers {pc, instr} beats over a
// valid/ready handshake. Decode receives them as a single bundle. Inside
// there is a two-entry skid buffer, which lets in_ready come straight from a
// flop. A taken branch (flush) discards every beat still in flight.
//
// Ports
//   clk        in   1              system clock, all state changes on posedge
//   rst_n      in   1              asynchronous active-low reset
//   in_valid   in   1              fetch presents a beat
//   in_ready   out  1              block can accept a beat (registered)
//   in_pc      in   PC_W           byte address of the fetched instruction
//   in_instr   in   INSTR_W        fetched instruction word
//   flush      in   1              taken branch: drop all buffered beats
//   out_valid  out  1              out_buf holds a valid beat
//   out_ready  in   1              decode consumes the beat this cycle
//   out_buf    out  PC_W+INSTR_W   {pc, instr}, with instr in the low bits
//   halt       out  1              (HALT_DETECT_EN only) sticky halt seen
//
// Configuration
//   HALT_DETECT_EN  When this macro is defined, a popped beat with
//                   instr[31:21] == 11'h7FF sets the sticky halt output.
//                   From then on the block accepts no more beats until reset.
//-----------------------------------------------------------------------------
module if_id_pipe_reg #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [PC_W-1:0]         in_pc,
    input  logic [INSTR_W-1:0]      in_instr,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [PC_W+INSTR_W-1:0] out_buf
`ifdef HALT_DETECT_EN
    ,
    output logic                    halt
`endif
);

    localparam int BUF_W = PC_W + INSTR_W;

    logic [BUF_W-1:0] main_buf, main_buf_n;
    logic [BUF_W-1:0] skid_buf, skid_buf_n;
    logic             main_v, main_v_n;
    logic             skid_v, skid_v_n;
    logic             in_ready_q;
    logic             halt_n;
    logic             acc;
    logic             pop;
    logic [BUF_W-1:0] in_beat;

    assign in_beat   = {in_pc, in_instr};
    assign acc       = in_valid & in_ready_q;
    assign pop       = main_v & out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = main_v;
    assign out_buf   = main_buf;

    // Next-state logic. The priority is flush first, then refilling main
    // (when it is empty or being popped), then parking the input in skid.
    always_comb begin
        // NOTE: every variable gets a default first, so no path can leave it
        // unassigned and infer a latch.
        main_buf_n = main_buf;
        skid_buf_n = skid_buf;
        main_v_n   = main_v;
        skid_v_n   = skid_v;

        if (flush) begin
            // A beat accepted in this cycle is dropped. A beat popped in
            // this cycle has already been taken by decode.
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (!main_v || pop) begin
            if (skid_v) begin
                main_buf_n = skid_buf;
                main_v_n   = 1'b1;
                if (acc) begin
                    skid_buf_n = in_beat;
                    skid_v_n   = 1'b1;
                end else begin
                    skid_v_n   = 1'b0;
                end
            end else begin
                // main_buf is written only on acceptance. A bubble therefore
                // leaves the old payload in place, and out_buf does not toggle.
                if (acc) begin
                    main_buf_n = in_beat;
                end
                main_v_n = acc;
                skid_v_n = 1'b0;
            end
        end else if (acc) begin
            // Main is stalled. Accepted input goes to skid. This branch is
            // never reached with skid_v=1, because in_ready is 0 then.
            skid_buf_n = in_beat;
            skid_v_n   = 1'b1;
        end
    end

`ifdef HALT_DETECT_EN
    logic halt_q;

    // Halt is sticky. It is raised by the popped beat, even when a flush
    // happens in the same cycle, and only reset clears it.
    assign halt_n = halt_q |
                    (pop && main_buf[INSTR_W-1:INSTR_W-11] == 11'h7FF);
    assign halt   = halt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_n;
        end
    end
`else
    assign halt_n = 1'b0;
`endif

    // NOTE: all sequential state uses non-blocking assignments. Every flop
    // then samples the pre-edge values, regardless of process order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data registers are reset along with the valid bits,
            // so out_buf reads 0 during reset instead of stale data.
            main_buf   <= '0;
            skid_buf   <= '0;
            main_v     <= 1'b0;
            skid_v     <= 1'b0;
            in_ready_q <= 1'b1;
        end else begin
            main_buf   <= main_buf_n;
            skid_buf   <= skid_buf_n;
            main_v     <= main_v_n;
            skid_v     <= skid_v_n;
            // in_ready is derived from next state and registered. This keeps
            // any combinational path from out_ready away from fetch.
            in_ready_q <= ~skid_v_n & ~halt_n;
        end
    end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
//-----------------------------------------------------------------------------
// tb_if_id_pipe_reg
//
// Directed bench for if_id_pipe_reg. A table of per-cycle vectors holds the
// inputs and the hand-computed outputs after each edge. A monitor collects
// every popped PC, and the collected list is compared in order at the end.
// Hand-written sequences cover asynchronous reset and, when the macro is
// defined, halt detection.
//-----------------------------------------------------------------------------
module tb_if_id_pipe_reg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int BUF_W   = PC_W + INSTR_W;

    localparam logic [31:0] I0 = 32'h8B02_0020;
    localparam logic [31:0] I1 = 32'h8B02_0021;
    localparam logic [31:0] I2 = 32'h8B02_0022;
    localparam logic [31:0] IH = 32'hFFE0_0000;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    in_pc;
    logic [INSTR_W-1:0] in_instr;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [BUF_W-1:0]   out_buf;
`ifdef HALT_DETECT_EN
    logic               halt;
`endif

    if_id_pipe_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_buf   (out_buf)
`ifdef HALT_DETECT_EN
        ,
        .halt      (halt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic               iv;
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               fl;
        logic               ordy;
        logic               e_ov;
        logic               e_ir;
        logic               chk_buf;
        logic [BUF_W-1:0]   e_buf;
    } vec_t;

    vec_t vecs[$];

    int checks = 0;
    int errors = 0;

    logic [PC_W-1:0] popped[$];
    logic [PC_W-1:0] exp_pops[$];

    // Record every handshake-completed pop in the order it happened.
    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready)
            popped.push_back(out_buf[BUF_W-1:INSTR_W]);
    end

    task automatic check(input string name, input logic [BUF_W-1:0] act,
                         input logic [BUF_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [PC_W-1:0] pc,
                                input logic [INSTR_W-1:0] instr,
                                input logic fl, input logic ordy,
                                input logic e_ov, input logic e_ir,
                                input logic chk_buf,
                                input logic [PC_W-1:0] e_pc,
                                input logic [INSTR_W-1:0] e_instr);
        vec_t v;
        v.iv = iv; v.pc = pc; v.instr = instr; v.fl = fl; v.ordy = ordy;
        v.e_ov = e_ov; v.e_ir = e_ir; v.chk_buf = chk_buf;
        v.e_buf = {e_pc, e_instr};
        return v;
    endfunction

    // Called at a negedge. Drive the inputs, let one posedge go by, then
    // sample 1 ns after it.
    task automatic apply(input vec_t v, input int idx);
        in_valid  = v.iv;
        in_pc     = v.pc;
        in_instr  = v.instr;
        flush     = v.fl;
        out_ready = v.ordy;
        @(posedge clk);
        #1;
        check($sformatf("v%0d out_valid", idx), BUF_W'(out_valid), BUF_W'(v.e_ov));
        check($sformatf("v%0d in_ready", idx), BUF_W'(in_ready), BUF_W'(v.e_ir));
        if (v.chk_buf)
            check($sformatf("v%0d out_buf", idx), out_buf, v.e_buf);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_pc = '0; in_instr = '0; flush = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        //        iv  pc      instr fl ordy ov ir chk e_pc    e_instr
        // T2 streaming: no bubbles, one-cycle latency
        vecs.push_back(mk(1, 64'h00, I0, 0, 1, 1, 1, 1, 64'h00, I0));
        vecs.push_back(mk(1, 64'h04, I1, 0, 1, 1, 1, 1, 64'h04, I1));
        vecs.push_back(mk(1, 64'h08, I2, 0, 1, 1, 1, 1, 64'h08, I2));
        vecs.push_back(mk(0, 64'h00, 0,  0, 1, 0, 1, 0, 64'h00, 0));
        // T3 stall: two beats accepted, the third refused, out_buf held
        vecs.push_back(mk(1, 64'h00, I0, 0, 0, 1, 1, 1, 64'h00, I0));
        vecs.push_back(mk(1, 64'h04, I1, 0, 0, 1, 0, 1, 64'h00, I0));
        vecs.push_back(mk(1, 64'h08, I2, 0, 0, 1, 0, 1, 64'h00, I0));
        // release: skid moves to main, in_ready comes back, PC=8 then taken
        vecs.push_back(mk(1, 64'h08, I2, 0, 1, 1, 1, 1, 64'h04, I1));
        vecs.push_back(mk(1, 64'h08, I2, 0, 1, 1, 1, 1, 64'h08, I2));
        vecs.push_back(mk(0, 64'h00, 0,  0, 1, 0, 1, 0, 64'h00, 0));
        // T4 flush with main and skid both full and a beat offered
        vecs.push_back(mk(1, 64'h20, I0, 0, 0, 1, 1, 1, 64'h20, I0));
        vecs.push_back(mk(1, 64'h24, I1, 0, 0, 1, 0, 1, 64'h20, I0));
        vecs.push_back(mk(1, 64'h40, I2, 1, 0, 0, 1, 0, 64'h00, 0));
        vecs.push_back(mk(0, 64'h00, 0,  0, 1, 0, 1, 0, 64'h00, 0));
        // T5 flush and pop in the same cycle
        vecs.push_back(mk(1, 64'h10, I0, 0, 0, 1, 1, 1, 64'h10, I0));
        vecs.push_back(mk(0, 64'h00, 0,  1, 1, 0, 1, 0, 64'h00, 0));
        vecs.push_back(mk(0, 64'h00, 0,  0, 1, 0, 1, 0, 64'h00, 0));
        // fill both entries before the asynchronous reset below
        vecs.push_back(mk(1, 64'h50, I1, 0, 0, 1, 1, 1, 64'h50, I1));
        vecs.push_back(mk(1, 64'h54, I2, 0, 0, 1, 0, 1, 64'h50, I1));

        exp_pops = '{64'h00, 64'h04, 64'h08, 64'h00, 64'h04, 64'h08, 64'h10};

        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset out_valid", BUF_W'(out_valid), BUF_W'(0));
        check("reset in_ready", BUF_W'(in_ready), BUF_W'(1));
        check("reset out_buf", out_buf, '0);
`ifdef HALT_DETECT_EN
        check("reset halt", BUF_W'(halt), BUF_W'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) apply(vecs[i], i);

        // T1: reset asserted mid-cycle takes effect immediately, with no edge.
        #2 rst_n = 1'b0;
        #1;
        check("async rst out_valid", BUF_W'(out_valid), BUF_W'(0));
        check("async rst in_ready", BUF_W'(in_ready), BUF_W'(1));
        check("async rst out_buf", out_buf, '0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef HALT_DETECT_EN
        // T6: the halt beat pops, halt sticks, and in_ready stays 0 through
        // a flush. Reset clears both.
        apply(mk(1, 64'h60, IH, 0, 1, 1, 1, 1, 64'h60, IH), 100);
        check("halt before pop", BUF_W'(halt), BUF_W'(0));
        apply(mk(1, 64'h64, I0, 0, 1, 1, 0, 1, 64'h64, I0), 101);
        check("halt after pop", BUF_W'(halt), BUF_W'(1));
        apply(mk(1, 64'h68, I1, 1, 0, 0, 0, 0, 64'h00, 0), 102);
        check("halt across flush", BUF_W'(halt), BUF_W'(1));
        apply(mk(1, 64'h6C, I2, 0, 1, 0, 0, 0, 64'h00, 0), 103);
        check("halt blocks input", BUF_W'(halt), BUF_W'(1));
        exp_pops.push_back(64'h60);
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("halt reset halt", BUF_W'(halt), BUF_W'(0));
        check("halt reset in_ready", BUF_W'(in_ready), BUF_W'(1));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`endif

        // FIFO order, with no duplicates and no losses apart from flushed beats
        check("pop count", BUF_W'(popped.size()), BUF_W'(exp_pops.size()));
        foreach (exp_pops[i]) begin
            if (i < popped.size())
                check($sformatf("pop[%0d] pc", i), BUF_W'(popped[i]), BUF_W'(exp_pops[i]));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
